// File: rtl/ahb_master_bridge.sv
// Command-to-AHB-Lite master bridge with overlapped address/data phases.
// Define AHB_MASTER_BRIDGE_BURST_EN to enable 4-beat INCR4 commands (default: single beats only).
module ahb_master_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_burst,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  done_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic [1:0]            HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;
  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_t;

  state_t                r_state;
  htrans_t               r_trans_q;
  logic                  r_stall;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_hwrite;
  logic [2:0]            r_hburst;
  logic                  r_cmd_write;
  logic                  r_burst;
  logic [1:0]            r_beat;
  logic                  r_dp_valid;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_hwdata;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_done;
  logic                  r_done_err;

  htrans_t               w_trans_new;
  htrans_t               w_trans;
  logic                  w_burst_req;
  logic [ADDR_WIDTH-1:0] w_base;
  logic                  w_acomp;
  logic                  w_dcomp;
  logic                  w_derr;
  logic                  w_last;

`ifdef AHB_MASTER_BRIDGE_BURST_EN
  assign w_burst_req = cmd_burst;
`else
  assign w_burst_req = cmd_burst & 1'b0;
`endif

  assign w_base = cmd_addr & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  assign w_last = (r_beat == (r_burst ? 2'd3 : 2'd0));

  always_comb begin
    w_trans_new = TR_IDLE;
    if (r_state == S_ADDR) begin
      if (!r_cmd_write || wd_valid)
        w_trans_new = (r_beat == 2'd0) ? TR_NONSEQ : TR_SEQ;
      else
        w_trans_new = (r_beat == 2'd0) ? TR_IDLE : TR_BUSY;
    end
  end

  // A transfer type shown in a waited cycle is replayed until HREADY returns,
  // so a late drop of wd_valid cannot retract a presented beat.
  assign w_trans = r_stall ? r_trans_q : w_trans_new;
  assign w_acomp = HREADY && w_trans[1] && (r_state == S_ADDR);
  assign w_dcomp = HREADY && r_dp_valid;
  assign w_derr  = w_dcomp && (HRESP != 2'b00);

  assign cmd_ready = (r_state == S_IDLE);
  assign wd_ready  = w_acomp && r_cmd_write;
  assign HTRANS    = w_trans;
  assign HADDR     = r_addr;
  assign HWRITE    = r_hwrite;
  assign HBURST    = r_hburst;
  assign HSIZE     = 3'b010;
  assign HWDATA    = r_hwdata;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign done      = r_done;
  assign done_err  = r_done_err;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_trans_q   <= TR_IDLE;
      r_stall     <= 1'b0;
      r_addr      <= '0;
      r_hwrite    <= 1'b0;
      r_hburst    <= 3'b000;
      r_cmd_write <= 1'b0;
      r_burst     <= 1'b0;
      r_beat      <= 2'd0;
      r_dp_valid  <= 1'b0;
      r_err       <= 1'b0;
      r_hwdata    <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_done      <= 1'b0;
      r_done_err  <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_stall    <= !HREADY;
      r_trans_q  <= w_trans;

      if (w_dcomp) begin
        r_dp_valid <= 1'b0;
        if (w_derr) begin
          r_err <= 1'b1;
        end else if (!r_cmd_write && !r_err) begin
          r_rd_valid <= 1'b1;
          r_rd_data  <= HRDATA;
        end
      end
      if (w_acomp) begin
        r_dp_valid <= 1'b1;
        if (r_cmd_write)
          r_hwdata <= wd_data;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_state     <= S_ADDR;
            r_addr      <= w_base;
            r_hwrite    <= cmd_write;
            r_cmd_write <= cmd_write;
            r_burst     <= w_burst_req;
            r_hburst    <= w_burst_req ? 3'b011 : 3'b000;
            r_beat      <= 2'd0;
            r_err       <= 1'b0;
          end
        end
        S_ADDR: begin
          if (w_acomp) begin
            r_beat <= r_beat + 2'd1;
            if (!w_last)
              r_addr <= r_addr + ADDR_WIDTH'(4);
          end
          // Leaving address issue: either the last beat went out (drain its
          // data phase) or an error stopped issue with nothing left in flight.
          if ((w_acomp && w_last) || w_derr) begin
            r_hwrite <= 1'b0;
            r_hburst <= 3'b000;
            if (w_acomp) begin
              r_state <= S_DATA;
            end else begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_done_err <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_dcomp) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_done_err <= r_err || w_derr;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_done_err <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ahb_master_bridge.md
AHB_MASTER_BRIDGE -- requirements
Module: ahb_master_bridge

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 8, address width; DATA_WIDTH, default 32, data width.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- HCLK  in  1  clock, single clock domain
- HRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  start byte address; bits [1:0] ignored, driven as 0
- cmd_burst  in  1  1=INCR4 (4 beats), 0=SINGLE
- wd_valid / wd_ready  in / out  1 / 1  per-beat write-data handshake
- wd_data  in  DATA_WIDTH  write beat data
- rd_valid  out  1  one-cycle pulse per good read beat
- rd_data  out  DATA_WIDTH  read beat data
- done  out  1  one-cycle pulse at end of command
- done_err  out  1  valid with done; 1 if any beat got ERROR
- HADDR  out  ADDR_WIDTH  AHB address
- HTRANS  out  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  out  1  transfer direction
- HSIZE  out  3  fixed 3'b010 (word)
- HBURST  out  3  000 SINGLE, 011 INCR4
- HWDATA  out  DATA_WIDTH  write data, data phase
- HREADY  in  1  bus ready
- HRDATA  in  DATA_WIDTH  read data
- HRESP  in  2  00 OKAY, 01 ERROR

Function
REQ-003 SHALL implement FSM states IDLE, ADDR, DATA, DONE.
REQ-004 IDLE: cmd_ready=1; on accept, latch command and go ADDR; cmd_ready=0 in all other states.
REQ-005 ADDR: present beat address. Drive NONSEQ for beat 0, SEQ for later beats; for writes, drive beat only while wd_valid=1, else IDLE (beat 0) or BUSY (later beats) with HADDR/HWRITE/HBURST held.
REQ-006 Beat address phase completes at posedge with HREADY=1 and HTRANS NONSEQ/SEQ; wd_ready=1 in that same cycle for writes, and wd_data is registered for the data phase.
REQ-007 Data phase is the cycle(s) after address completion and ends at the posedge with HREADY=1; HWDATA is held stable throughout.
REQ-008 Pipelining: the next beat's address phase SHALL overlap the previous beat's data phase; no IDLE cycle between beats of a burst unless write data is absent.
REQ-009 HADDR for beat n = (cmd_addr & ~3) + 4n, modulo 2^ADDR_WIDTH (wraps at top of address space).
REQ-010 Read beat: at data-phase completion with HRESP=OKAY, rd_valid=1 and rd_data=HRDATA on the next cycle (1-cycle latency).
REQ-011 HRESP=ERROR at data-phase completion: set sticky error; issue no further beats (HTRANS=IDLE next). An address phase already completed still finishes its data phase, but its rd_valid is suppressed. No rd_valid for the error beat.
REQ-012 DONE: after last data phase completes, pulse done for 1 cycle with done_err; return to IDLE. Next command is accepted no earlier than the cycle after done.
REQ-013 HREADY=0 SHALL stall all phases with every AHB output held.
REQ-014 Idle outputs: HTRANS=IDLE, HWRITE=0, HBURST=000, HSIZE=3'b010.

Reset
REQ-015 HRESETn low SHALL immediately force: state IDLE, HADDR=0, HTRANS=00, HWRITE=0, HBURST=000, HWDATA=0, cmd_ready=1, wd_ready=0, rd_valid=0, rd_data=0, done=0, done_err=0, error flag cleared.
REQ-016 Reset mid-command SHALL abandon the command with no done pulse.

Configuration
REQ-017 Macro AHB_MASTER_BRIDGE_BURST_EN: defined -> cmd_burst=1 runs a 4-beat INCR4 command with HBURST=011. Undefined -> cmd_burst is ignored and every command is 1 beat with HBURST=000.

Verification
REQ-018 Single write 0x04, wd_data 0xDEADBEEF, HREADY=1 -> NONSEQ at 0x04 for 1 cycle; HWDATA=0xDEADBEEF next cycle; done=1, done_err=0.
REQ-019 Single read 0x04 with HRDATA=0xDEADBEEF -> rd_valid 1 cycle with rd_data 0xDEADBEEF; done=1.
REQ-020 With BURST_EN: burst write at 0xF8, wd_valid low on beat 2 -> HTRANS NONSEQ,SEQ,BUSY,SEQ,SEQ; HADDR F8,FC,00,00,04; done after 4 data phases.
REQ-021 Burst read with HREADY low 2 cycles during beat 1 data phase -> all AHB outputs held; 4 rd_valid pulses in order.
REQ-022 Burst read, HRESP=ERROR on beat 1 -> beat 2 data phase completes without rd_valid; no beat 3 issued; done_err=1; only 1 rd_valid total.
REQ-023 HRESETn asserted mid-burst -> all outputs at reset values same cycle; no done; a new command is accepted after release.
